ifm_fetch: RTL

Read-side master for the input buffer. It accepts a fetch command (word address and word count) and splits it into fixed-length AXI-style read bursts toward the bus slave (`axi_bus_sim` in simulation). It collects the returned beats into an internal first-word-fall-through FIFO and streams them to the input-buffer write port over a valid/ready interface. The slave has no `rready`, so the block uses credit-based issue: a burst is requested only when the FIFO can absorb all of it.

---
 rtl/ifm_fetch_if.sv | 41 ++++
 rtl/ifm_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ifm_fetch_if.sv
// Command, AXI-style read and output-stream signals of the input-buffer fetch master.
// master: the fetch block side; slave: the command source / bus slave / consumer side.
interface ifm_fetch_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_len;

    logic [AW-1:0] araddr;
    logic          arvalid;
    logic [3:0]    arburst;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rlast;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        output araddr, arvalid, arburst,
        input  arready, rdata, rvalid, rlast,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        input  araddr, arvalid, arburst,
        output arready, rdata, rvalid, rlast,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/ifm_fetch.sv
// Input-buffer fetch master: splits a (word address, word count) command into
// fixed BL-word read bursts, issues a burst only when the FIFO can absorb it
// (the slave has no rready), and streams the words out of a FWFT FIFO.
// Optional checker: define IFM_FETCH_CHK_EN to enable the sticky err flag.
module ifm_fetch #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int BURST_LOG  = 3,
    parameter int FIFO_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ifm_fetch_if.master  bus,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int BL = 1 << BURST_LOG;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] addr_q;
    logic [15:0]   len_q;
    logic [15:0]   rcv_q;
    logic [15:0]   rcv_upd;
    logic [AW-1:0] araddr_q;
    logic          arvalid_q;
    logic          done_q;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic cmd_take;
    logic issue_fire;
    logic beat_keep;
    logic cmd_finish;
    logic free_ok;
    logic fifo_full;
    logic push;
    logic pop;

    assign free_ok   = (int'(count) + BL) <= FIFO_DEPTH;
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign pop       = (count != '0) && bus.out_ready;
    assign push      = beat_keep && (!fifo_full || pop);

    assign bus.cmd_ready = (state == IDLE);
    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = araddr_q;
    assign bus.arburst   = 4'(BURST_LOG);
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = (count != '0) ? mem[rd_ptr] : '0;
    assign busy          = (state != IDLE);
    assign done          = done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_nxt  = state;
        cmd_take   = 1'b0;
        issue_fire = 1'b0;
        beat_keep  = 1'b0;
        cmd_finish = 1'b0;
        rcv_upd    = rcv_q;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_take = 1'b1;
                    if (bus.cmd_len != '0) state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.arready && free_ok) begin
                    issue_fire = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                beat_keep = bus.rvalid && (rcv_q < len_q);
                if (beat_keep) rcv_upd = rcv_q + 16'd1;
                // A beat arriving together with rlast is counted before deciding
                // whether another burst is needed.
                if (bus.rlast) begin
                    if (rcv_upd >= len_q) begin
                        cmd_finish = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        state_nxt  = ISSUE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command registers, burst address generation and registered pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            len_q     <= '0;
            rcv_q     <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            arvalid_q <= issue_fire;
            done_q    <= (cmd_take && (bus.cmd_len == '0)) || cmd_finish;
            if (cmd_take) begin
                addr_q <= bus.cmd_addr;
                len_q  <= bus.cmd_len;
                rcv_q  <= '0;
            end
            if (issue_fire) begin
                araddr_q <= addr_q;
                addr_q   <= addr_q + AW'(BL);
            end
            if (beat_keep) rcv_q <= rcv_upd;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rdata;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef IFM_FETCH_CHK_EN
    localparam int BW = BURST_LOG + 1;

    logic          err_q;
    logic [BW-1:0] beat_cnt;
    logic          beat_over;

    assign beat_over = (state == WAIT) && bus.rvalid && (beat_cnt == BW'(BL));
    assign err       = err_q;

    // Sticky protocol checker: overflow drop, stray beat, over-long burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (issue_fire) beat_cnt <= '0;
            else if ((state == WAIT) && bus.rvalid && !beat_over) beat_cnt <= beat_cnt + BW'(1);
            if ((beat_keep && fifo_full && !pop) ||
                (bus.rvalid && (state != WAIT)) ||
                beat_over)
                err_q <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
